// File: rtl/intr_ctrl_pkg.sv
// Shared interrupt-controller definitions: source indices, FSM state type, priority encoder.
package intr_ctrl_pkg;

    localparam int INTR_COUNT   = 4;
    localparam int INTR_VIDEO   = 0;
    localparam int INTR_COPPER  = 1;
    localparam int INTR_BLIT    = 2;
    localparam int INTR_TIMER   = 3;

    typedef enum logic [1:0] {
        INTR_IDLE,
        INTR_ASSERT,
        INTR_HOLDOFF
    } intr_state_t;

    // Index of the lowest set bit (lowest index = highest priority); 0 when none set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_ctrl.sv
// Interrupt controller: pending status, mask, priority report and pulse/level bus line.
// All outputs registered (1-cycle latency); strobes are always accepted, no backpressure.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_INTR       = INTR_COUNT,
    parameter int PULSE_CYCLES   = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    input  logic [NUM_INTR-1:0]         intr_signal_i,
    input  logic [NUM_INTR-1:0]         intr_force_i,
    input  logic [NUM_INTR-1:0]         intr_clear_i,
    input  logic [NUM_INTR-1:0]         intr_mask_i,
    input  logic                        level_mode_i,
    output logic [NUM_INTR-1:0]         intr_status_o,
    output logic                        intr_pending_o,
    output logic [$clog2(NUM_INTR)-1:0] intr_src_o,
    output logic                        bus_intr_o
);

    localparam int SW   = $clog2(NUM_INTR);
    localparam int MAXC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    intr_state_t           state;
    logic [CW-1:0]         cnt;
    logic                  retrig;
    logic [NUM_INTR-1:0]   mask_q;

    logic [NUM_INTR-1:0]   set_v;
    logic [NUM_INTR-1:0]   status_nx;
    logic [NUM_INTR-1:0]   new_evt;
    logic [NUM_INTR-1:0]   enabled_nx;
    logic                  any_evt;
    logic                  rearm;

    // Unmasking an already-pending source is treated as a fresh event.
    always_comb begin
        set_v      = intr_signal_i | intr_force_i;
        status_nx  = (intr_status_o | set_v) & ~intr_clear_i;
        new_evt    = (set_v & ~intr_status_o & ~intr_clear_i & intr_mask_i)
                   | (intr_mask_i & ~mask_q & intr_status_o & ~intr_clear_i);
        enabled_nx = status_nx & intr_mask_i;
        any_evt    = |new_evt;
        rearm      = (retrig | any_evt) & (|enabled_nx);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            intr_status_o  <= '0;
            mask_q         <= '0;
            intr_pending_o <= 1'b0;
            intr_src_o     <= '0;
            bus_intr_o     <= 1'b0;
            state          <= INTR_IDLE;
            cnt            <= '0;
            retrig         <= 1'b0;
        end else begin
            intr_status_o  <= status_nx;
            mask_q         <= intr_mask_i;
            intr_pending_o <= |enabled_nx;
            intr_src_o     <= SW'(lowest_set(8'(enabled_nx)));

            if (level_mode_i) begin
                state      <= INTR_IDLE;
                cnt        <= '0;
                retrig     <= 1'b0;
                bus_intr_o <= |enabled_nx;
            end else begin
                case (state)
                    INTR_IDLE: begin
                        retrig <= 1'b0;
                        if (any_evt) begin
                            state      <= INTR_ASSERT;
                            cnt        <= PULSE_LOAD;
                            bus_intr_o <= 1'b1;
                        end else begin
                            bus_intr_o <= 1'b0;
                        end
                    end
                    INTR_ASSERT: begin
                        if (cnt != '0) begin
                            cnt        <= cnt - CW'(1);
                            bus_intr_o <= 1'b1;
                            retrig     <= retrig | any_evt;
                        end else if (HOLDOFF_CYCLES == 0) begin
                            // No holdoff window: the exit decision happens on this edge.
                            retrig <= 1'b0;
                            if (rearm) begin
                                cnt        <= PULSE_LOAD;
                                bus_intr_o <= 1'b1;
                            end else begin
                                state      <= INTR_IDLE;
                                bus_intr_o <= 1'b0;
                            end
                        end else begin
                            state      <= INTR_HOLDOFF;
                            cnt        <= HOLD_LOAD;
                            bus_intr_o <= 1'b0;
                            retrig     <= retrig | any_evt;
                        end
                    end
                    INTR_HOLDOFF: begin
                        if (cnt != '0) begin
                            cnt        <= cnt - CW'(1);
                            bus_intr_o <= 1'b0;
                            retrig     <= retrig | any_evt;
                        end else begin
                            retrig <= 1'b0;
                            if (rearm) begin
                                state      <= INTR_ASSERT;
                                cnt        <= PULSE_LOAD;
                                bus_intr_o <= 1'b1;
                            end else begin
                                state      <= INTR_IDLE;
                                bus_intr_o <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state      <= INTR_IDLE;
                        cnt        <= '0;
                        retrig     <= 1'b0;
                        bus_intr_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: timeline reference model feeds an expectation queue.
module tb_intr_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int H = 16;

    logic         clk;
    logic         reset_n_i;
    logic [N-1:0] intr_signal_i;
    logic [N-1:0] intr_force_i;
    logic [N-1:0] intr_clear_i;
    logic [N-1:0] intr_mask_i;
    logic         level_mode_i;
    logic [N-1:0] intr_status_o;
    logic         intr_pending_o;
    logic [1:0]   intr_src_o;
    logic         bus_intr_o;

    intr_ctrl #(.NUM_INTR(N), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .intr_signal_i  (intr_signal_i),
        .intr_force_i   (intr_force_i),
        .intr_clear_i   (intr_clear_i),
        .intr_mask_i    (intr_mask_i),
        .level_mode_i   (level_mode_i),
        .intr_status_o  (intr_status_o),
        .intr_pending_o (intr_pending_o),
        .intr_src_o     (intr_src_o),
        .bus_intr_o     (bus_intr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] status;
        logic         pend;
        logic [1:0]   src;
        logic         bus;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: pulses are tracked as a time window rather than a state machine.
    logic [N-1:0] m_status;
    logic [N-1:0] m_mask_q;
    bit           m_active;
    bit           m_retrig;
    int           m_start;
    int           cyc;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_status"}, 8'(intr_status_o), 8'h0);
        chk({nm, "_pending"}, 8'(intr_pending_o), 8'h0);
        chk({nm, "_src"}, 8'(intr_src_o), 8'h0);
        chk({nm, "_bus"}, 8'(bus_intr_o), 8'h0);
    endtask

    task automatic model_reset();
        m_status = '0;
        m_mask_q = '0;
        m_active = 0;
        m_retrig = 0;
        m_start  = 0;
    endtask

    task automatic step(input logic [N-1:0] sg, input logic [N-1:0] fr,
                        input logic [N-1:0] cl, input logic [N-1:0] mk, input logic lv);
        logic [N-1:0] evt, st_n, en;
        exp_t e;
        @(negedge clk);
        intr_signal_i = sg;
        intr_force_i  = fr;
        intr_clear_i  = cl;
        intr_mask_i   = mk;
        level_mode_i  = lv;
        cyc++;
        evt  = ((sg | fr) & ~m_status & ~cl & mk) | (mk & ~m_mask_q & m_status & ~cl);
        st_n = (m_status | sg | fr) & ~cl;
        en   = st_n & mk;
        e.status = st_n;
        e.pend   = |en;
        e.src    = 2'd0;
        for (int i = N - 1; i >= 0; i--) if (en[i]) e.src = 2'(i);
        if (lv) begin
            m_active = 0;
            m_retrig = 0;
            e.bus    = |en;
        end else begin
            if (m_active && cyc == m_start + P + H) begin
                if ((m_retrig || evt != 0) && en != 0) m_start = cyc;
                else m_active = 0;
                m_retrig = 0;
            end else if (m_active) begin
                if (evt != 0) m_retrig = 1;
            end else if (evt != 0) begin
                m_active = 1;
                m_start  = cyc;
                m_retrig = 0;
            end
            e.bus = m_active && (cyc - m_start) < P;
        end
        m_status = st_n;
        m_mask_q = mk;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [N-1:0] mk, input logic lv);
        for (int i = 0; i < n; i++) step('0, '0, '0, mk, lv);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("status", 8'(intr_status_o), 8'(mon_e.status));
            chk("pending", 8'(intr_pending_o), 8'(mon_e.pend));
            chk("src", 8'(intr_src_o), 8'(mon_e.src));
            chk("bus_intr", 8'(bus_intr_o), 8'(mon_e.bus));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        model_reset();
        reset_n_i     = 1'b0;
        intr_signal_i = '1;
        intr_force_i  = '1;
        intr_clear_i  = '1;
        intr_mask_i   = '1;
        level_mode_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        intr_signal_i = '0;
        intr_force_i  = '0;
        intr_clear_i  = '0;
        intr_mask_i   = '0;
        level_mode_i  = 1'b0;
        reset_n_i     = 1'b1;
        idle(4, 4'hF, 1'b0);

        // Single pulse then holdoff, no second pulse.
        step(4'b0001, '0, '0, 4'b0001, 1'b0);
        idle(30, 4'b0001, 1'b0);
        step('0, '0, 4'hF, 4'b0001, 1'b0);

        // Retrigger: second source during the pulse.
        step(4'b0010, '0, '0, 4'b0110, 1'b0);
        idle(2, 4'b0110, 1'b0);
        step(4'b0100, '0, '0, 4'b0110, 1'b0);
        idle(40, 4'b0110, 1'b0);
        step('0, '0, 4'hF, 4'b0110, 1'b0);

        // Same-cycle set and clear on one bit.
        step(4'b0001, '0, 4'b0001, 4'b0001, 1'b0);
        idle(10, 4'b0001, 1'b0);

        // Retrigger cancelled by clearing during holdoff.
        step(4'b0010, '0, '0, 4'b0110, 1'b0);
        idle(2, 4'b0110, 1'b0);
        step('0, 4'b0100, '0, 4'b0110, 1'b0);
        idle(8, 4'b0110, 1'b0);
        step('0, '0, 4'b0110, 4'b0110, 1'b0);
        idle(30, 4'b0110, 1'b0);

        // Pending while masked, then unmask, then level mode until clear.
        step(4'b1000, '0, '0, 4'b0000, 1'b0);
        idle(3, 4'b0000, 1'b0);
        step('0, '0, '0, 4'b1000, 1'b0);
        idle(30, 4'b1000, 1'b0);
        idle(5, 4'b1000, 1'b1);
        step('0, '0, 4'b1000, 4'b1000, 1'b1);
        idle(3, 4'b1000, 1'b1);
        idle(3, 4'b1000, 1'b0);

        // Reset in the middle of a pulse.
        step(4'b0001, '0, '0, 4'b0001, 1'b0);
        idle(3, 4'b0001, 1'b0);
        @(posedge clk);
        #3;
        reset_n_i = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        check_zero("reset_low");
        intr_signal_i = '0;
        intr_force_i  = '0;
        intr_clear_i  = '0;
        intr_mask_i   = '0;
        level_mode_i  = 1'b0;
        reset_n_i     = 1'b1;
        idle(25, 4'b0001, 1'b0);

        // Randomized traffic.
        begin
            logic [N-1:0] mk;
            logic         lv;
            logic [N-1:0] sg, fr, cl;
            mk = 4'hF;
            lv = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                sg = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
                fr = ($urandom_range(0, 24) == 0) ? N'($urandom) : '0;
                cl = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
                if ($urandom_range(0, 31) == 0) mk = N'($urandom);
                if ($urandom_range(0, 149) == 0) lv = ~lv;
                step(sg, fr, cl, mk, lv);
            end
        end

        idle(2, '0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
